// File: rtl/muldiv_seq_pkg.sv
// Shared RV32M definitions (package rv32_pkg): operand width, iteration
// counter width, funct3 encodings of the M ops and the sequencer state enum.
package rv32_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    // funct3 encodings of the M extension ops
    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] DIVU   = 3'd5;
    localparam logic [2:0] REM    = 3'd6;
    localparam logic [2:0] REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // Divide/remainder ops all have funct3[2] set
    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV, REM
    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Core <-> multiply/divide sequencer connection.
//
// Handshake: Start is a level request held by the core for as long as the
// current instruction is an M op, with MUL_Opcode/Operand_A/Operand_B valid
// alongside it. Stall (= Start & ~Done) is the back-pressure: the core holds
// PC and instruction while it is high. Done is a one-cycle strobe; Result is
// valid only in that cycle and is written back then. Flush aborts any op
// and takes priority over Start.
interface muldiv_seq_if;
    import rv32_pkg::*;

    logic            Start;
    logic [2:0]      MUL_Opcode;
    logic [XLEN-1:0] Operand_A;
    logic [XLEN-1:0] Operand_B;
    logic            Flush;
    logic [XLEN-1:0] Result;
    logic            Busy;
    logic            Done;
    logic            Stall;

    modport master (
        output Start, MUL_Opcode, Operand_A, Operand_B, Flush,
        input  Result, Busy, Done, Stall
    );

    modport slave (
        input  Start, MUL_Opcode, Operand_A, Operand_B, Flush,
        output Result, Busy, Done, Stall
    );

endinterface

// File: rtl/muldiv_seq_md_iter_unit.sv
// Iterative datapath for the M-op sequencer: one radix-2 step per cycle,
// either shift-add multiply or restoring divide, on unsigned magnitudes.
// Multiply: {acc, sr} is the product, sr starts as the multiplier.
// Divide:   sr ends as the quotient, acc as the remainder.
module md_iter_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic         is_div,
    input  logic [W-1:0] load_sr,
    input  logic [W-1:0] load_opnd,
    output logic [W-1:0] acc,
    output logic [W-1:0] sr
);

    logic [W-1:0] opnd_q;
    logic [W-1:0] acc_d;
    logic [W-1:0] sr_d;
    logic [W:0]   mul_sum;
    logic [W:0]   div_shift;
    logic [W-1:0] div_diff;
    logic         div_ge;

    // Next accumulator / shift register for one multiply or divide step
    always_comb begin
        mul_sum   = {1'b0, acc} + (sr[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
        div_shift = {acc, sr[W-1]};
        // True difference is below 2**W whenever it is used, so W bits suffice
        div_diff  = div_shift[W-1:0] - opnd_q;
        div_ge    = (div_shift >= {1'b0, opnd_q});
        if (is_div) begin
            acc_d = div_ge ? div_diff : div_shift[W-1:0];
            sr_d  = {sr[W-2:0], div_ge};
        end else begin
            acc_d = mul_sum[W:1];
            sr_d  = {mul_sum[0], sr[W-1:1]};
        end
    end

    // Operand latch on load, one iteration per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            sr     <= '0;
            opnd_q <= '0;
        end else if (load) begin
            acc    <= '0;
            sr     <= load_sr;
            opnd_q <= load_opnd;
        end else if (step) begin
            acc <= acc_d;
            sr  <= sr_d;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle sequencer for RV32M ops (MUL..REMU). Owns the IDLE/CALC/FIX/DONE
// FSM, iteration counter, sign handling and divide special cases; the
// iterative datapath lives in md_iter_unit.
// Optional feature macro: MULDIV_FAST_MUL_EN -- when defined, MUL* ops use a
// single-cycle 33x33 signed multiply and finish one cycle after Start.
module muldiv_seq
    import rv32_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_N,
    muldiv_seq_if.slave bus,
    output md_state_t   dbg_state
);

    md_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]      op_q;
    logic            a_neg_q, b_neg_q;
    logic [XLEN-1:0] result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            latch_req, iter_load, iter_step, result_load;

    logic            req_div;
    logic            a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;
    logic            div_by_zero, div_ovf, special;
    logic [XLEN-1:0] special_result;
    logic            fast_take;
    logic [XLEN-1:0] fast_result;

    logic [XLEN-1:0] acc, sr;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] quot_s, rem_s, fix_result;

    // Decode of the incoming request: sign flags, magnitudes, special cases
    always_comb begin
        req_div     = is_div_op(bus.MUL_Opcode);
        a_neg_in    = a_is_signed(bus.MUL_Opcode) & bus.Operand_A[XLEN-1];
        b_neg_in    = b_is_signed(bus.MUL_Opcode) & bus.Operand_B[XLEN-1];
        a_mag_in    = a_neg_in ? -bus.Operand_A : bus.Operand_A;
        b_mag_in    = b_neg_in ? -bus.Operand_B : bus.Operand_B;
        div_by_zero = req_div && (bus.Operand_B == '0);
        div_ovf     = ((bus.MUL_Opcode == DIV) || (bus.MUL_Opcode == REM)) &&
                      (bus.Operand_A == 32'h8000_0000) && (bus.Operand_B == 32'hFFFF_FFFF);
        special     = div_by_zero | div_ovf;
        // funct3[1] distinguishes REM/REMU from DIV/DIVU
        if (div_by_zero)
            special_result = bus.MUL_Opcode[1] ? bus.Operand_A : 32'hFFFF_FFFF;
        else
            special_result = bus.MUL_Opcode[1] ? 32'h0 : bus.Operand_A;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_p;

    // Single-cycle signed multiply on sign/zero-extended operands
    always_comb begin
        fast_a      = {a_is_signed(bus.MUL_Opcode) & bus.Operand_A[XLEN-1], bus.Operand_A};
        fast_b      = {b_is_signed(bus.MUL_Opcode) & bus.Operand_B[XLEN-1], bus.Operand_B};
        fast_p      = fast_a * fast_b;
        fast_take   = ~req_div;
        fast_result = (bus.MUL_Opcode == MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    end
`else
    // Multiplies always take the iterative path
    always_comb begin
        fast_take   = 1'b0;
        fast_result = '0;
    end
`endif

    // Sign correction of the finished iteration and result selection
    always_comb begin
        prod_s = (a_neg_q ^ b_neg_q) ? -{acc, sr} : {acc, sr};
        quot_s = (a_neg_q ^ b_neg_q) ? -sr : sr;
        rem_s  = a_neg_q ? -acc : acc;
        case (op_q)
            MUL:                fix_result = prod_s[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_result = prod_s[2*XLEN-1:XLEN];
            DIV, DIVU:          fix_result = quot_s;
            default:            fix_result = rem_s;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; Flush overrides everything
    always_comb begin
        state_d = state_q;
        if (bus.Flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.Start) state_d = (special || fast_take) ? DONE : CALC;
                CALC: if (cnt_q == '0) state_d = FIX;
                FIX:  state_d = DONE;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: datapath controls and next values of registered outputs
    always_comb begin
        latch_req   = 1'b0;
        iter_load   = 1'b0;
        iter_step   = 1'b0;
        result_load = 1'b0;
        result_d    = result_q;
        if (!bus.Flush) begin
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        latch_req = 1'b1;
                        if (special) begin
                            result_load = 1'b1;
                            result_d    = special_result;
                        end else if (fast_take) begin
                            result_load = 1'b1;
                            result_d    = fast_result;
                        end else begin
                            iter_load = 1'b1;
                        end
                    end
                end
                CALC: iter_step = 1'b1;
                FIX: begin
                    result_load = 1'b1;
                    result_d    = fix_result;
                end
                default: ;
            endcase
        end
        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // Registered outputs, counter and latched request attributes
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            op_q     <= MUL;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (result_load) result_q <= result_d;
            if (latch_req) begin
                cnt_q   <= CNT_W'(XLEN - 1);
                op_q    <= bus.MUL_Opcode;
                a_neg_q <= a_neg_in;
                b_neg_q <= b_neg_in;
            end else if (iter_step) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    md_iter_unit #(.W(XLEN)) u_iter (
        .clk       (Clk),
        .rst_n     (Rst_N),
        .load      (iter_load),
        .step      (iter_step),
        .is_div    (is_div_op(op_q)),
        .load_sr   (req_div ? a_mag_in : b_mag_in),
        .load_opnd (req_div ? b_mag_in : a_mag_in),
        .acc       (acc),
        .sr        (sr)
    );

    assign bus.Result = result_q;
    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.Stall  = bus.Start & ~done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic results, latency, stall length,
// divide special cases, flush, mid-op reset and back-to-back ops.
module tb_muldiv_seq;
    import rv32_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic      clk;
    logic      rst_n;
    md_state_t dbg_state;
    int        checks;
    int        failures;

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .Clk       (clk),
        .Rst_N     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op, wait for Done, check latency, stall length and result
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int  cyc;
        int  stalls;
        logic seen;
        bus.MUL_Opcode = op;
        bus.Operand_A  = a;
        bus.Operand_B  = b;
        bus.Start      = 1'b1;
        #1;
        stalls = (bus.Stall === 1'b1) ? 1 : 0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (bus.Busy !== (exp_lat > 1)) begin
                    failures++;
                    $display("FAIL %s busy_first: got %b want %b", name, bus.Busy, (exp_lat > 1));
                end
            end
            if (bus.Done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus.Stall === 1'b1) stalls++;
                // operands changed mid-op must be ignored
                bus.Operand_A = ~a;
                bus.Operand_B = ~b;
            end
        end
        checks++;
        if (cyc != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        checks++;
        if (bus.Result !== exp_res) begin
            failures++;
            $display("FAIL %s result: got %h want %h", name, bus.Result, exp_res);
        end
        checks++;
        if (stalls != exp_lat) begin
            failures++;
            $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_lat);
        end
        checks++;
        if (bus.Stall !== 1'b0) begin
            failures++;
            $display("FAIL %s stall_on_done: got %b want 0", name, bus.Stall);
        end
        bus.Start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, bus.Done, bus.Busy);
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.Start      = 1'b0;
        bus.Flush      = 1'b0;
        bus.MUL_Opcode = 3'd0;
        bus.Operand_A  = '0;
        bus.Operand_B  = '0;
        #1;
        checks++;
        if (bus.Result !== 32'h0) begin
            failures++;
            $display("FAIL reset_result: got %h want 0", bus.Result);
        end
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got busy=%b done=%b stall=%b want 0 0 0", bus.Busy, bus.Done, bus.Stall);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        run_op("mul_7_m3",  MUL, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mul_m5_m6", MUL, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_001E, MUL_LAT);
    endtask

    task automatic test_mulh();
        run_op("mulh_min",    MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhu_min",   MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhsu_m1_2", MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT);
        run_op("mulhu_max_2", MULHU,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, MUL_LAT);
    endtask

    task automatic test_div();
        run_op("div_m20_3",  DIV,  32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, DIV_LAT);
        run_op("rem_m20_3",  REM,  32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, DIV_LAT);
        run_op("div_20_m3",  DIV,  32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, DIV_LAT);
        run_op("rem_20_m3",  REM,  32'd20,        32'hFFFF_FFFD, 32'h0000_0002, DIV_LAT);
        run_op("remu_100_7", REMU, 32'd100,       32'd7,         32'h0000_0002, DIV_LAT);
    endtask

    task automatic test_special();
        run_op("divu_by_zero", DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_by_zero",  REM,  32'd5,         32'd0,         32'h0000_0005, 1);
        run_op("div_overflow", DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_overflow", REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    endtask

    // Start dropped mid-op: the op still completes
    task automatic test_start_drop();
        int   cyc;
        logic seen;
        bus.MUL_Opcode = DIVU;
        bus.Operand_A  = 32'd100;
        bus.Operand_B  = 32'd7;
        bus.Start      = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 3) bus.Start = 1'b0;
            if (bus.Done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (cyc != DIV_LAT) begin
            failures++;
            $display("FAIL start_drop_latency: got %0d want %0d", cyc, DIV_LAT);
        end
        checks++;
        if (bus.Result !== 32'd14) begin
            failures++;
            $display("FAIL start_drop_result: got %h want %h", bus.Result, 32'd14);
        end
        bus.Start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int pulses;
        bus.MUL_Opcode = DIV;
        bus.Operand_A  = 32'hFFFF_FFEC;
        bus.Operand_B  = 32'd3;
        bus.Start      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.Busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_busy_before: got %b want 1", bus.Busy);
        end
        bus.Flush = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL flush_abort: got busy=%b done=%b state=%0d want 0 0 %0d",
                     bus.Busy, bus.Done, dbg_state, IDLE);
        end
        // Flush still high with Start held: must stay idle
        @(posedge clk); #1;
        checks++;
        if (bus.Busy !== 1'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL flush_priority: got busy=%b state=%0d want 0 %0d", bus.Busy, dbg_state, IDLE);
        end
        bus.Flush = 1'b0;
        bus.Start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.Done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL flush_no_done: got %0d pulses want 0", pulses);
        end
    endtask

    // Asynchronous reset in the middle of an op
    task automatic test_reset_mid_op();
        bus.MUL_Opcode = DIV;
        bus.Operand_A  = 32'd1000;
        bus.Operand_B  = 32'd7;
        bus.Start      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.Busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_busy_before: got %b want 1", bus.Busy);
        end
        #2;
        rst_n     = 1'b0;
        bus.Start = 1'b0;
        #1;
        checks++;
        if (bus.Result !== 32'h0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got result=%h busy=%b done=%b stall=%b want 0 0 0 0",
                     bus.Result, bus.Busy, bus.Done, bus.Stall);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            failures++;
            $display("FAIL rst_mid_state: got %0d want %0d", dbg_state, IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("div_after_rst", DIV, 32'd1000, 32'd7, 32'd142, DIV_LAT);
    endtask

    // MUL then DIVU with Start held high throughout
    task automatic test_back_to_back();
        int   cyc;
        int   pulses;
        logic seen;
        pulses = 0;
        bus.MUL_Opcode = MUL;
        bus.Operand_A  = 32'd123;
        bus.Operand_B  = 32'd456;
        bus.Start      = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.Done === 1'b1) seen = 1'b1;
        end
        if (seen) pulses++;
        checks++;
        if (cyc != MUL_LAT) begin
            failures++;
            $display("FAIL b2b_mul_latency: got %0d want %0d", cyc, MUL_LAT);
        end
        checks++;
        if (bus.Result !== 32'd56088) begin
            failures++;
            $display("FAIL b2b_mul_result: got %h want %h", bus.Result, 32'd56088);
        end
        // core advances to the next instruction after the Done cycle
        bus.MUL_Opcode = DIVU;
        bus.Operand_A  = 32'd100;
        bus.Operand_B  = 32'd7;
        @(posedge clk); #1;
        checks++;
        if (dbg_state !== IDLE || bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_gap: got state=%0d done=%b busy=%b want %0d 0 0",
                     dbg_state, bus.Done, bus.Busy, IDLE);
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.Done === 1'b1) seen = 1'b1;
        end
        if (seen) pulses++;
        checks++;
        if (cyc != DIV_LAT) begin
            failures++;
            $display("FAIL b2b_divu_latency: got %0d want %0d", cyc, DIV_LAT);
        end
        checks++;
        if (bus.Result !== 32'd14) begin
            failures++;
            $display("FAIL b2b_divu_result: got %h want %h", bus.Result, 32'd14);
        end
        bus.Start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.Done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL b2b_done_pulses: got %0d want 2", pulses);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_start_drop();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
